// File: rtl/ram_ws_rs_data_banked_pkg.sv
// Shared types and helpers for the banked L1.5 instruction-cache data store.
package ram_ws_rs_data_banked_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // One byte enable per 8 data bits.
  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ram_ws_rs_data_bank.sv
// One way of the data store: DEPTH x DATA_WIDTH single-ported array with
// byte-enabled writes and a registered read port.
module ram_ws_rs_data_bank
  import ram_ws_rs_data_banked_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int BE_WIDTH   = be_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BE_WIDTH-1:0]   be,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-enabled array write; the array itself has no reset, the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (ce && we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read; holds its value until the next read of this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (ce && re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_ws_rs_data_banked.sv
// Multi-way data store for the L1.5 instruction cache: NB_WAYS parallel banks,
// req/gnt handshake, registered read-valid and a clear sequencer that zeroes
// the whole array after reset or flush.
//
// state | meaning
// CLEAR | zeroing entry clr_cnt in all ways, requests not granted
// READY | array usable, gnt = req & ~flush
module ram_ws_rs_data_banked
  import ram_ws_rs_data_banked_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int NB_WAYS    = 4,
  parameter int BE_WIDTH   = be_width(DATA_WIDTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               testmode,
  input  logic                               flush,
  output logic                               init_done,
  input  logic                               req,
  output logic                               gnt,
  input  logic                               write,
  input  logic [NB_WAYS-1:0]                 way_mask,
  input  logic [ADDR_WIDTH-1:0]              addr,
  input  logic [DATA_WIDTH-1:0]              wdata,
  input  logic [BE_WIDTH-1:0]                be,
  output logic                               rvalid,
  output logic [NB_WAYS-1:0][DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic                  clearing;
  logic                  acc_read, acc_write;
  logic                  bank_ce;
  logic [ADDR_WIDTH-1:0] bank_addr;
  logic [DATA_WIDTH-1:0] bank_wdata;
  logic [BE_WIDTH-1:0]   bank_be;

  // State register and clear counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state, clear counter advance and handshake outputs.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    gnt         = 1'b0;
    init_done   = 1'b0;
    clearing    = 1'b0;
    case (state)
      CLEAR: begin
        clearing = 1'b1;
        if (flush) begin
          clr_cnt_nxt = '0;
        end else if (clr_cnt == CNT_LAST) begin
          state_nxt   = READY;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + CNT_ONE;
        end
      end
      READY: begin
        init_done = 1'b1;
        gnt       = req & ~flush;
        if (flush) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Access decode and clear-path muxing; testmode only opens the bank clock enable.
  always_comb begin
    acc_write  = gnt & write;
    acc_read   = gnt & ~write;
    bank_ce    = testmode | clearing | gnt;
    bank_addr  = clearing ? clr_cnt : addr;
    bank_wdata = clearing ? '0 : wdata;
    bank_be    = clearing ? '1 : be;
  end

  // Read-valid follows a granted read by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid <= 1'b0;
    else        rvalid <= acc_read;
  end

  for (genvar w = 0; w < NB_WAYS; w++) begin : g_way
    ram_ws_rs_data_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BE_WIDTH   (BE_WIDTH)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (bank_ce),
      .we    (clearing | (acc_write & way_mask[w])),
      .re    (acc_read & way_mask[w]),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .be    (bank_be),
      .rdata (rdata[w])
    );
  end

endmodule

// File: tb/tb_ram_ws_rs_data_banked.sv
// Bench for ram_ws_rs_data_banked: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the store.
module tb_ram_ws_rs_data_banked;

  localparam int DW    = 128;
  localparam int AW    = 6;
  localparam int NW    = 4;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   testmode = 1'b0;
  logic                   flush = 1'b0;
  logic                   init_done;
  logic                   req = 1'b0;
  logic                   gnt;
  logic                   write = 1'b0;
  logic [NW-1:0]          way_mask = '0;
  logic [AW-1:0]          addr = '0;
  logic [DW-1:0]          wdata = '0;
  logic [BW-1:0]          be = '0;
  logic                   rvalid;
  logic [NW-1:0][DW-1:0]  rdata;

  ram_ws_rs_data_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NB_WAYS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .testmode(testmode), .flush(flush),
    .init_done(init_done), .req(req), .gnt(gnt), .write(write),
    .way_mask(way_mask), .addr(addr), .wdata(wdata), .be(be),
    .rvalid(rvalid), .rdata(rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model
  logic [DW-1:0] m_mem [NW][DEPTH];
  logic [DW-1:0] m_rdata [NW];
  bit            m_ready = 0;
  int            m_cnt = 0;
  bit            m_rvalid = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_cnt = 0; m_rvalid = 0;
    for (int w = 0; w < NW; w++) m_rdata[w] = '0;
  endtask

  // Apply the inputs present at a rising edge to the model.
  task automatic model_edge();
    if (!rst_n) return;
    if (!m_ready) begin
      for (int w = 0; w < NW; w++) m_mem[w][m_cnt] = '0;
      m_rvalid = 0;
      if (flush) m_cnt = 0;
      else if (m_cnt == DEPTH - 1) begin m_ready = 1; m_cnt = 0; end
      else m_cnt++;
    end else if (flush) begin
      m_ready = 0; m_cnt = 0; m_rvalid = 0;
    end else if (req) begin
      m_rvalid = !write;
      for (int w = 0; w < NW; w++) begin
        if (way_mask[w]) begin
          if (write) begin
            for (int b = 0; b < BW; b++)
              if (be[b]) m_mem[w][addr][8*b +: 8] = wdata[8*b +: 8];
          end else begin
            m_rdata[w] = m_mem[w][addr];
          end
        end
      end
    end else begin
      m_rvalid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    chk("gnt", DW'(gnt), DW'(rst_n && m_ready && req && !flush));
    chk("init_done", DW'(init_done), DW'(rst_n && m_ready));
    chk("rvalid", DW'(rvalid), DW'(m_rvalid));
    for (int w = 0; w < NW; w++) chk($sformatf("rdata[%0d]", w), rdata[w], m_rdata[w]);
  end

  task automatic idle();
    req = 0; write = 0; flush = 0; way_mask = '0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic count_init(input string name);
    int n = 0;
    while (!init_done && n < 200) begin tick(); n++; end
    chk(name, DW'(n), DW'(64));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  localparam logic [DW-1:0] ASC    = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [DW-1:0] ASC_LO = 128'h0000000000000000_0706050403020100;
  localparam logic [DW-1:0] A5     = {16{8'hA5}};

  initial begin
    for (int w = 0; w < NW; w++)
      for (int i = 0; i < DEPTH; i++) m_mem[w][i] = '0;
    model_reset();
    idle();
    repeat (3) tick();
    rst_n = 1;
    chk("gnt_before_init", DW'(gnt), DW'(0));
    count_init("init_cycles_after_reset");

    // read all ways at the last entry
    req = 1; write = 0; way_mask = 4'b1111; addr = 6'h3F;
    tick();
    idle();
    chk("rvalid_first_read", DW'(rvalid), DW'(1));
    for (int w = 0; w < NW; w++) chk("rdata_cleared_3f", rdata[w], '0);
    tick();
    chk("rvalid_after_read", DW'(rvalid), DW'(0));

    // partial-byte write to way 1
    req = 1; write = 1; way_mask = 4'b0010; addr = 6'd5; wdata = ASC; be = 16'h00FF;
    tick();
    chk("rvalid_after_write", DW'(rvalid), DW'(0));
    req = 1; write = 0; way_mask = 4'b1111; addr = 6'd5;
    tick();
    idle();
    chk("be_way1", rdata[1], ASC_LO);
    chk("be_way0", rdata[0], '0);
    chk("be_way3", rdata[3], '0);

    // write ways 0/3 then read immediately
    req = 1; write = 1; way_mask = 4'b1001; addr = 6'd9; wdata = A5; be = '1;
    tick();
    req = 1; write = 0; way_mask = 4'b1001; addr = 6'd9;
    tick();
    idle();
    chk("raw_way0", rdata[0], A5);
    chk("raw_way3", rdata[3], A5);
    chk("hold_way1", rdata[1], ASC_LO);
    chk("hold_way2", rdata[2], '0);

    // back-to-back reads
    for (int i = 0; i < 8; i++) begin
      req = 1; write = 0; way_mask = 4'b1111; addr = AW'(i);
      tick();
      chk("b2b_rvalid", DW'(rvalid), DW'(1));
    end
    idle();
    tick();

    // flush with simultaneous read request
    flush = 1; req = 1; write = 0; way_mask = 4'b1111; addr = 6'd9;
    #1;
    chk("gnt_under_flush", DW'(gnt), DW'(0));
    tick();
    idle();
    chk("init_done_drop", DW'(init_done), DW'(0));
    count_init("init_cycles_after_flush");
    req = 1; write = 0; way_mask = 4'b1111; addr = 6'd9;
    tick();
    idle();
    chk("flushed_addr9_way0", rdata[0], '0);
    chk("flushed_addr9_way3", rdata[3], '0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      req      = ($urandom_range(3) != 0);
      write    = $urandom_range(1);
      flush    = ($urandom_range(79) == 0);
      way_mask = NW'($urandom);
      addr     = AW'($urandom_range(15));
      wdata    = {$urandom, $urandom, $urandom, $urandom};
      be       = BW'($urandom);
      tick();
    end
    idle();

    // async reset in the middle of a clear
    flush = 1;
    tick();
    flush = 0;
    begin
      int g = 0;
      while (m_cnt != 30 && g < 200) begin tick(); g++; end
      chk("reach_cnt30", DW'(m_cnt), DW'(30));
    end
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_init_done", DW'(init_done), DW'(0));
    chk("rst_rvalid", DW'(rvalid), DW'(0));
    for (int w = 0; w < NW; w++) chk("rst_rdata", rdata[w], '0);
    repeat (2) tick();
    rst_n = 1;
    count_init("init_cycles_after_midclear_reset");
    req = 1; write = 0; way_mask = 4'b1111; addr = 6'd3;
    tick();
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_ws_rs_data_banked.md
Name: ram_ws_rs_data_banked

Overview:
Parametrised multi-way data store for the L1.5 instruction cache. One single-ported bank per way; all ways read in parallel, any subset written with byte enables. Adds a req/gnt handshake, registered read-valid, and a hardware clear sequencer that zeroes the whole array after reset or on flush. Sits between the L1.5 cache controller and its data storage.

Parameters:
DATA_WIDTH, 128, bits per way entry; multiple of 8
ADDR_WIDTH, 6, index bits; DEPTH = 2**ADDR_WIDTH entries per way
NB_WAYS, 4, number of ways/banks; >= 1
BE_WIDTH, DATA_WIDTH/8, derived byte-enable width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
testmode  in  1  test mode; forces array clock gating transparent, no functional effect
flush  in  1  single-cycle pulse: restart the clear sequence
init_done  out  1  high when clear complete and array usable
req  in  1  access request
gnt  out  1  request accepted this cycle
write  in  1  1 = write, 0 = read
way_mask  in  NB_WAYS  ways selected for access
addr  in  ADDR_WIDTH  entry index
wdata  in  DATA_WIDTH  write data, shared by all selected ways
be  in  BE_WIDTH  byte enables for writes
rvalid  out  1  rdata valid, one cycle after granted read
rdata  out  NB_WAYS x DATA_WIDTH  per-way read data

Behaviour:
- Reset (rst_n low, async): init_done=0, gnt=0, rvalid=0, rdata all zero, FSM=CLEAR, clear counter=0. Array contents not reset by rst_n; the clear sequence zeroes them.
- FSM states: CLEAR, READY.
- CLEAR: each cycle writes zero to entry clr_cnt in all ways, clr_cnt++. On clr_cnt == DEPTH-1, go to READY next cycle. Takes exactly DEPTH cycles. gnt=0, init_done=0 throughout.
- READY: init_done=1; gnt = req & ~flush, combinational.
- flush in READY: next cycle CLEAR, clr_cnt=0, init_done=0. flush in CLEAR restarts the counter at 0. flush and req in the same cycle: flush wins, req not granted, no array access.
- Granted write: for every way w with way_mask[w]=1, byte b of entry addr updated with wdata byte b iff be[b]=1; other bytes and ways unchanged. Takes effect at the clock edge. way_mask=0 or be=0 is a legal no-op. rvalid=0 next cycle.
- Granted read: entry addr of ways in way_mask registered into rdata[w] at the edge; rvalid=1 for exactly the next cycle. Ways not in way_mask keep their previous rdata. be ignored.
- rdata holds its value until the next granted read that selects that way. Not cleared by flush.
- Single port: one access per cycle. Read-after-write to the same entry in consecutive cycles returns the newly written bytes.
- Back-to-back granted reads give rvalid high continuously, one result per cycle.
- Ungranted req (CLEAR, or flush): no state change, rvalid=0 next cycle. Requester must hold the request until gnt.
- Async reset mid-CLEAR or mid-read: outputs go to reset values immediately; the sequence restarts after deassertion.

Decomposition:
- Package ram_ws_rs_data_banked_pkg: FSM state enum {CLEAR, READY}, BE width derivation function.
- Sub-module ram_ws_rs_data_bank: one way, DEPTH x DATA_WIDTH, byte-enabled write, registered read, enable inputs. Top instantiates NB_WAYS copies plus the FSM, clear counter and rvalid register. The clear path muxes addr/wdata/be to clr_cnt/0/all-ones with all ways selected.

Test Plan:
- Reset release, DEPTH=64: init_done rises exactly 64 cycles after deassertion, gnt=0 before it; then read all ways at addr 0x3F -> rdata all zero, rvalid 1 cycle later.
- Write way_mask=4'b0010, addr 5, wdata=0x00..0F_ascending, be=16'h00FF, then read way_mask=4'b1111 addr 5 -> way1 low 8 bytes = 0x07..00 pattern, high bytes 0, other ways 0.
- Write ways 0 and 3 addr 9 with 0xA5 repeated, be all ones; next cycle read addr 9 way_mask=4'b1001 -> rdata[0] = rdata[3] = 0xA5.., rdata[1] and rdata[2] unchanged from the prior read.
- 8 back-to-back reads to addr 0..7 -> rvalid high 8 consecutive cycles, data in order, no bubbles.
- flush with simultaneous read req -> gnt=0, init_done drops the next cycle, 64 clear cycles, previously written addr 9 reads 0 afterwards.
- rst_n asserted mid-clear at clr_cnt=30 -> outputs zero immediately; full 64-cycle clear after release.
